// File: rtl/decoder_scan_if.sv
// Control/status bundle for decoder_scan: the master drives enable, mode, select and load;
// the decoder returns the one-hot output, its index and the scan wrap pulse.
interface decoder_scan_if #(
    parameter int SEL_W = 2
);
    localparam int OUT_W = 1 << SEL_W;

    logic             en;
    logic             mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, sel, load,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2**SEL_W one-hot decoder with a direct-decode mode and an
// auto-scan mode that holds each index for DWELL enabled cycles.
module decoder_scan #(
    parameter int SEL_W      = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic           clock,
    input  logic           reset_n,
    decoder_scan_if.slave  bus
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int DW_W  = (DWELL <= 2) ? 1 : $clog2(DWELL);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [OUT_W-1:0] INACT      = {OUT_W{ACTIVE_LOW}};

    logic [SEL_W-1:0] idx_q, idx_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;

    // Index to present on the output next cycle, and whether any bit is active at all.
    logic [SEL_W-1:0] out_idx;
    logic             out_act;

    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        wrap_d  = 1'b0;
        out_idx = idx_q;
        out_act = 1'b0;
        if (!bus.en) begin
            out_act = 1'b0;
        end else if (!bus.mode || bus.load) begin
            idx_d   = bus.sel;
            dwell_d = '0;
            out_idx = bus.sel;
            out_act = 1'b1;
        end else if (dwell_q != DWELL_LAST) begin
            dwell_d = dwell_q + 1'b1;
            out_act = 1'b1;
        end else begin
            dwell_d = '0;
            idx_d   = idx_q + 1'b1;
            out_idx = idx_q + 1'b1;
            out_act = 1'b1;
            wrap_d  = (idx_q == {SEL_W{1'b1}});
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_dec
            assign out_d[gi] = INACT[gi] ^ (out_act && (out_idx == SEL_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx_q   <= '0;
            dwell_q <= '0;
            out_q   <= INACT;
            wrap_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a default instance (2-bit select, dwell 4, active high)
// and a 3-bit, active-low, dwell-1 instance, each driven through its own interface.
module tb_decoder_scan;
    logic clock = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    decoder_scan_if #(.SEL_W(2)) bus_a ();
    decoder_scan_if #(.SEL_W(3)) bus_b ();

    decoder_scan #(.SEL_W(2), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
        .clock   (clock),
        .reset_n (rst_a),
        .bus     (bus_a)
    );

    decoder_scan #(.SEL_W(3), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .clock   (clock),
        .reset_n (rst_b),
        .bus     (bus_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %s got %0h exp %0h", tag, got, exp);
        end else begin
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [3:0] e_out, input logic [1:0] e_idx,
                           input logic e_wrap);
        check_eq({tag, ".out"},  32'(bus_a.out),  32'(e_out));
        check_eq({tag, ".idx"},  32'(bus_a.idx),  32'(e_idx));
        check_eq({tag, ".wrap"}, 32'(bus_a.wrap), 32'(e_wrap));
    endtask

    initial begin
        logic [1:0] ei;
        logic [2:0] eb;
        bus_a.en = 1'b0; bus_a.mode = 1'b0; bus_a.sel = '0; bus_a.load = 1'b0;
        bus_b.en = 1'b0; bus_b.mode = 1'b0; bus_b.sel = '0; bus_b.load = 1'b0;

        // Reset state of the default instance.
        step();
        step();
        check_a("rst", 4'b0000, 2'd0, 1'b0);
        rst_a = 1'b1;

        // Direct decode of every select value.
        bus_a.en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus_a.sel = 2'(s);
            step();
            check_a($sformatf("direct%0d", s), 4'(1 << s), 2'(s), 1'b0);
        end

        // Enable gating: outputs inactive, index held, recovery one cycle after en rises.
        bus_a.sel = 2'd2;
        step();
        check_a("gate.pre", 4'b0100, 2'd2, 1'b0);
        bus_a.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_a($sformatf("gate.off%0d", k), 4'b0000, 2'd2, 1'b0);
        end
        bus_a.en = 1'b1;
        step();
        check_a("gate.on", 4'b0100, 2'd2, 1'b0);

        // Scan from reset: idx = k/4 after edge k, wrap on edge 16 only.
        bus_a.en = 1'b0;
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        bus_a.en = 1'b1;
        bus_a.mode = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            step();
            ei = 2'((k / 4) % 4);
            check_a($sformatf("scan%0d", k), 4'(1 << ei), ei, (k == 16));
        end

        // Load mid-dwell: restart scan, load index 2 at dwell count 2.
        rst_a = 1'b0;
        #2;
        rst_a = 1'b1;
        step();
        step();
        check_a("load.pre", 4'b0001, 2'd0, 1'b0);
        bus_a.load = 1'b1;
        bus_a.sel  = 2'd2;
        step();
        bus_a.load = 1'b0;
        check_a("load.0", 4'b0100, 2'd2, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check_a($sformatf("load.%0d", k), 4'b0100, 2'd2, 1'b0);
        end
        step();
        check_a("load.adv", 4'b1000, 2'd3, 1'b0);

        // Asynchronous reset between edges while out = 1000.
        #2;
        rst_a = 1'b0;
        #1;
        check_a("arst", 4'b0000, 2'd0, 1'b0);
        rst_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            ei = 2'(k / 4);
            check_a($sformatf("arst.scan%0d", k), 4'(1 << ei), ei, 1'b0);
        end

        // Wide active-low instance with DWELL = 1.
        check_eq("b.rst.out", 32'(bus_b.out), 32'hFF);
        check_eq("b.rst.idx", 32'(bus_b.idx), 32'd0);
        rst_b = 1'b1;
        bus_b.en  = 1'b1;
        bus_b.sel = 3'd5;
        step();
        check_eq("b.direct.out", 32'(bus_b.out), 32'hDF);
        check_eq("b.direct.idx", 32'(bus_b.idx), 32'd5);
        bus_b.mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            eb = 3'((5 + k) % 8);
            check_eq($sformatf("b.scan%0d.idx", k),  32'(bus_b.idx),  32'(eb));
            check_eq($sformatf("b.scan%0d.out", k),  32'(bus_b.out),  32'(8'(~(8'd1 << eb))));
            check_eq($sformatf("b.scan%0d.wrap", k), 32'(bus_b.wrap), 32'(eb == 3'd0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered N-to-2^N one-hot decoder that supersedes the fixed 2-to-4 decoder. Besides direct decoding of `sel`, it has an auto-scan mode that steps the active output through all 2^SEL_W positions, holding each for a programmable number of cycles. It drives multiplexed display digit enables and row strobes in lab designs. Output polarity is selectable at elaboration.

## Interface
- `SEL_W`, default 2: select width; OUT_W = 2**SEL_W outputs; legal range 1..5.
- `DWELL`, default 4: cycles each index is held in scan mode; must be >= 1.
- `ACTIVE_LOW`, default 0: 1 means the active output is driven 0 and inactive outputs are driven 1.
- `clock`  in  1  rising-edge clock; the block uses this single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  enable; 0 forces all outputs inactive and freezes scan state.
- `mode`  in  1  0 = direct decode of `sel`; 1 = auto-scan.
- `sel`  in  SEL_W  decode index in direct mode; load value in scan mode.
- `load`  in  1  scan mode only: jump to index `sel`.
- `out`  out  OUT_W  registered one-hot output, polarity set by ACTIVE_LOW.
- `idx`  out  SEL_W  registered index currently driven on `out`.
- `wrap`  out  1  one-cycle pulse when the scan wraps from OUT_W-1 to 0.

## Operation
- Internal state is `idx_q` (SEL_W bits) and `dwell_q`, a counter of width max(1, clog2(DWELL)). The outputs `out`, `idx` and `wrap` are all flops.
- INACT denotes the inactive pattern: all zeros, or all ones when ACTIVE_LOW = 1. onehot(i) sets bit i active and every other bit to INACT.
- On reset: `idx` = 0, `dwell_q` = 0, `out` = INACT, `wrap` = 0. Reset applies immediately with no clock edge and has the highest priority.
- Priority at each rising edge: en = 0, then mode = 0, then load, then the dwell step.
- en = 0: `out` <= INACT, `wrap` <= 0, `idx` and `dwell_q` hold.
- en = 1, mode = 0 (direct): `idx` <= `sel`, `out` <= onehot(`sel`), `dwell_q` <= 0, `wrap` <= 0. `load` is ignored.
- en = 1, mode = 1, load = 1: `idx` <= `sel`, `out` <= onehot(`sel`), `dwell_q` <= 0, `wrap` <= 0.
- en = 1, mode = 1, load = 0, `dwell_q` < DWELL-1: `dwell_q` increments, and `out` <= onehot(`idx`) with `idx` unchanged.
- en = 1, mode = 1, load = 0, `dwell_q` = DWELL-1: `dwell_q` <= 0, and `idx` <= (`idx`+1) mod OUT_W.
  - `out` <= onehot(new `idx`).
  - `wrap` <= 1 only if the old `idx` = OUT_W-1; otherwise `wrap` <= 0.
- Invariant: whenever `out` is not INACT, `out` = onehot(`idx`). Exactly one bit is ever active.
- Switching mode 1 -> 0 mid-scan: `idx` follows `sel` from the next edge.
- Switching mode 0 -> 1: scanning resumes from the current `idx` with `dwell_q` = 0, so the first index receives a full DWELL cycles.
- DWELL = 1: the index advances on every enabled scan edge.
- Index arithmetic is modulo OUT_W; no illegal index exists.

## Timing
- Latency: 1 cycle from `sel`, `en`, `mode` or `load` to `out` and `idx`. There is no combinational path from inputs to outputs.
- Scan period: each index is held for exactly DWELL enabled cycles. A full scan takes OUT_W*DWELL enabled cycles.
- `wrap` is high for one cycle, in the same cycle that `out` returns to onehot(0). It is 0 whenever en = 0 or mode = 0.
- en low for k cycles extends the current dwell by k cycles; the dwell count is not lost.
- reset_n asserted mid-scan: all outputs go to reset values asynchronously. After release, the first enabled edge behaves as the first edge after reset.
- `load` held high across several cycles re-loads on every edge, so the scan is frozen at `sel`.

## Test plan
1. Direct mode, default parameters:
   - Stimulus: en = 1, mode = 0; sel = 00, 01, 10, 11, each held 1 cycle.
   - Response: `out` = 0001, 0010, 0100, 1000, each 1 cycle after its `sel`; `idx` matches; `wrap` = 0 throughout.
2. Enable gating:
   - Stimulus: in direct mode with sel = 10, drop en for 3 cycles.
   - Response: `out` = 0000 from the next edge; `idx` holds 2; `out` = 0100 returns 1 cycle after en rises.
3. Scan from reset, DWELL = 4:
   - Stimulus: en = 1, mode = 1.
   - Response: `out` = 0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each. At cycle 17 `out` = 0001 and `wrap` = 1 for exactly one cycle.
4. Load mid-dwell:
   - Stimulus: during scan at idx = 0 with dwell count 2, pulse load = 1 with sel = 10.
   - Response: `out` = 0100 next edge; `idx` = 2 is held for a full 4 cycles, then `idx` = 3.
5. Asynchronous reset:
   - Stimulus: assert reset_n = 0 between clock edges while `out` = 1000.
   - Response: `out` = 0000, `idx` = 0, `wrap` = 0 immediately, with no clock edge. After release, scan restarts at index 0 with a full dwell.
6. Instance with SEL_W = 3, ACTIVE_LOW = 1, DWELL = 1:
   - Stimulus: reset.
   - Response: `out` = 8'hFF.
   - Stimulus: direct mode with sel = 5.
   - Response: `out` = 8'b1101_1111.
   - Stimulus: switch to scan.
   - Response: `idx` steps 5, 6, 7, 0; `wrap` = 1 on the cycle `idx` becomes 0.
